// File: rtl/pwm_pkg.sv
// Shared encodings for the multiphase PWM: carrier mode, count direction
// and the period-boundary predicate.
package pwm_pkg;

   typedef enum logic {
      MODE_EDGE   = 1'b0,
      MODE_CENTER = 1'b1
   } carrier_mode_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // A period starts on the tick that leaves carrier 0 while counting up.
   function automatic logic is_boundary(input logic tick, input logic at_zero, input logic dir);
      return tick && at_zero && (dir == DIR_UP);
   endfunction

endpackage

// File: rtl/pwm_deadtime_ch.sv
// One complementary output pair: raw edge detect, dead-band counter and
// registered high/low drive. clear (disable/fault) restarts from both-off.
module pwm_deadtime_ch
   import pwm_pkg::*;
#(
   parameter int DT_WIDTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   input  logic                raw,
   input  logic [DT_WIDTH-1:0] dt,
   output logic                high,
   output logic                low
);

   logic                raw_q;
   logic                fresh;
   logic [DT_WIDTH-1:0] cnt;
   logic                start;

   // After reset/clear the current raw level is treated as a new edge, so the
   // first active output is always reached through a full dead-band.
   assign start = fresh || (raw != raw_q);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         raw_q <= 1'b0;
         fresh <= 1'b1;
         cnt   <= '0;
         high  <= 1'b0;
         low   <= 1'b0;
      end else begin
         raw_q <= raw;
         fresh <= 1'b0;
         if (start) begin
            high <= raw && (dt == '0);
            low  <= !raw && (dt == '0);
            cnt  <= dt;
         end else if (cnt != '0) begin
            cnt <= cnt - DT_WIDTH'(1);
            if (cnt == DT_WIDTH'(1)) begin
               high <= raw_q;
               low  <= !raw_q;
            end
         end
      end
   end

endmodule

// File: rtl/pwm_multiphase_dt.sv
// Multi-channel complementary PWM with shared prescaler/carrier, shadowed
// duty/dead-time/mode and per-channel dead-band. Optional macro: PWM_FAULT_EN.
module pwm_multiphase_dt
   import pwm_pkg::*;
#(
   parameter int CHANNELS   = 3,
   parameter int R          = 8,
   parameter int TIMER_BITS = 8,
   parameter int DT_WIDTH   = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      center_mode,
   input  logic [CHANNELS*(R+1)-1:0] duty,
   input  logic [TIMER_BITS-1:0]     final_value,
   input  logic [DT_WIDTH-1:0]       dt_value,
   input  logic                      load,
`ifdef PWM_FAULT_EN
   input  logic                      fault_in,
   input  logic                      fault_clear,
   output logic                      fault_latched,
`endif
   output logic [CHANNELS-1:0]       pwm_high,
   output logic [CHANNELS-1:0]       pwm_low,
   output logic                      period_start
);

   localparam logic [R-1:0] CARRIER_MAX = '1;
   localparam logic [R-1:0] CARRIER_ONE = R'(1);

   logic [TIMER_BITS-1:0]     presc;
   logic [R-1:0]              carrier;
   logic                      dir;
   logic                      tick;
   logic                      boundary;
   logic [CHANNELS*(R+1)-1:0] duty_sh;
   logic [DT_WIDTH-1:0]       dt_sh;
   carrier_mode_t             mode_sh;
   logic                      update_pending;
   logic [CHANNELS-1:0]       raw;
   logic                      ch_clear;

   assign tick         = enable && (presc == final_value);
   assign boundary     = is_boundary(tick, carrier == '0, dir);
   assign period_start = boundary;

   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         presc   <= '0;
         carrier <= '0;
         dir     <= DIR_UP;
      end else begin
         presc <= tick ? '0 : presc + TIMER_BITS'(1);
         if (tick) begin
            if (mode_sh == MODE_EDGE) begin
               carrier <= carrier + CARRIER_ONE;
               dir     <= DIR_UP;
            end else if (dir == DIR_UP) begin
               carrier <= (carrier == CARRIER_MAX) ? carrier - CARRIER_ONE : carrier + CARRIER_ONE;
               if (carrier == CARRIER_MAX) dir <= DIR_DOWN;
            end else begin
               carrier <= carrier - CARRIER_ONE;
               if (carrier == CARRIER_ONE) dir <= DIR_UP;
            end
         end
      end
   end

   // A load coinciding with a boundary keeps the request pending for the next one.
   always_ff @(posedge clk) begin
      if (reset) begin
         duty_sh        <= '0;
         dt_sh          <= '0;
         mode_sh        <= MODE_EDGE;
         update_pending <= 1'b1;
      end else begin
         if (boundary && update_pending) begin
            duty_sh <= duty;
            dt_sh   <= dt_value;
            mode_sh <= carrier_mode_t'(center_mode);
         end
         if (load)          update_pending <= 1'b1;
         else if (boundary) update_pending <= 1'b0;
      end
   end

`ifdef PWM_FAULT_EN
   always_ff @(posedge clk) begin
      if (reset)            fault_latched <= 1'b0;
      else if (fault_in)    fault_latched <= 1'b1;
      else if (fault_clear) fault_latched <= 1'b0;
   end

   // fault_in acts combinationally so the pins drop on the very next clock.
   assign ch_clear = !enable || fault_in || fault_latched;
`else
   assign ch_clear = !enable;
`endif

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      assign raw[k] = ({1'b0, carrier} < duty_sh[k*(R+1) +: R+1]);

      pwm_deadtime_ch #(
         .DT_WIDTH(DT_WIDTH)
      ) u_ch (
         .clk  (clk),
         .reset(reset),
         .clear(ch_clear),
         .raw  (raw[k]),
         .dt   (dt_sh),
         .high (pwm_high[k]),
         .low  (pwm_low[k])
      );
   end

endmodule

// File: tb/tb_pwm_multiphase_dt.sv
// Directed self-checking bench for pwm_multiphase_dt; the fault scenario is
// compiled in when PWM_FAULT_EN is defined.
module tb_pwm_multiphase_dt;

   localparam int CHANNELS   = 3;
   localparam int R          = 8;
   localparam int TIMER_BITS = 8;
   localparam int DT_WIDTH   = 8;

   logic                      clk = 1'b0;
   logic                      reset;
   logic                      enable;
   logic                      center_mode;
   logic [CHANNELS*(R+1)-1:0] duty;
   logic [TIMER_BITS-1:0]     final_value;
   logic [DT_WIDTH-1:0]       dt_value;
   logic                      load;
   logic [CHANNELS-1:0]       pwm_high;
   logic [CHANNELS-1:0]       pwm_low;
   logic                      period_start;
`ifdef PWM_FAULT_EN
   logic                      fault_in;
   logic                      fault_clear;
   logic                      fault_latched;
`endif

   int checks   = 0;
   int failures = 0;
   int overlaps = 0;

   always #5 clk = ~clk;

   pwm_multiphase_dt #(
      .CHANNELS(CHANNELS), .R(R), .TIMER_BITS(TIMER_BITS), .DT_WIDTH(DT_WIDTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .center_mode (center_mode),
      .duty        (duty),
      .final_value (final_value),
      .dt_value    (dt_value),
      .load        (load),
`ifdef PWM_FAULT_EN
      .fault_in    (fault_in),
      .fault_clear (fault_clear),
      .fault_latched(fault_latched),
`endif
      .pwm_high    (pwm_high),
      .pwm_low     (pwm_low),
      .period_start(period_start)
   );

   // Shoot-through monitor, sampled every cycle of every test.
   always @(negedge clk) begin
      if ((pwm_high & pwm_low) !== '0) overlaps++;
   end

   task automatic set_duty(input int k, input int d);
      duty[k*(R+1) +: R+1] = (R+1)'(d);
   endtask

   task automatic wait_ps(input int bound, output int n);
      n = -1;
      for (int i = 1; i <= bound; i++) begin
         @(negedge clk);
         load = 1'b0;
         if (period_start === 1'b1) begin
            n = i;
            break;
         end
      end
      if (n < 0) begin
         checks++; failures++;
         $display("FAIL wait_ps: no period_start within %0d clk", bound);
      end
   endtask

   task automatic measure(input int k, input int n, output int hi, output int lo,
                          output int gap, output int hi_fall);
      logic prev_hi;
      hi = 0; lo = 0; gap = 0; hi_fall = -1;
      prev_hi = pwm_high[k];
      for (int i = 0; i < n; i++) begin
         if (pwm_high[k] === 1'b1) hi++;
         if (pwm_low[k] === 1'b1) lo++;
         if (pwm_high[k] === 1'b0 && pwm_low[k] === 1'b0) gap++;
         if (i > 0 && prev_hi === 1'b1 && pwm_high[k] === 1'b0 && hi_fall < 0) hi_fall = i;
         prev_hi = pwm_high[k];
         @(negedge clk);
         load = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; center_mode = 1'b0; load = 1'b0;
      duty = '0; final_value = '0; dt_value = '0;
      repeat (3) @(negedge clk);
      checks++; if (pwm_high !== 3'b000) begin failures++; $display("FAIL reset_high: got %b want 000", pwm_high); end
      checks++; if (pwm_low !== 3'b000) begin failures++; $display("FAIL reset_low: got %b want 000", pwm_low); end
      checks++; if (period_start !== 1'b0) begin failures++; $display("FAIL reset_ps: got %b want 0", period_start); end
      reset = 1'b0;
      @(negedge clk);
      checks++; if ((pwm_high | pwm_low) !== 3'b000) begin failures++; $display("FAIL disabled_out: got %b/%b want 000/000", pwm_high, pwm_low); end
      enable = 1'b1;
      #1;
      checks++; if (period_start !== 1'b1) begin failures++; $display("FAIL enable_first_tick: got %b want 1", period_start); end
      @(negedge clk);
      checks++; if (period_start !== 1'b0) begin failures++; $display("FAIL ps_pulse_width: got %b want 0", period_start); end
   endtask

   task automatic test_edge();
      int n, hi, lo, gap, hf;
      center_mode = 1'b0; dt_value = 8'd5; final_value = '0;
      for (int k = 0; k < CHANNELS; k++) set_duty(k, 128);
      load = 1'b1;
      wait_ps(600, n);
      wait_ps(600, n);
      checks++; if (n !== 256) begin failures++; $display("FAIL edge_period: got %0d want 256", n); end
      for (int k = 0; k < CHANNELS; k++) begin
         measure(k, 256, hi, lo, gap, hf);
         checks++; if (hi !== 123) begin failures++; $display("FAIL edge_high_ch%0d: got %0d want 123", k, hi); end
         checks++; if (lo !== 123) begin failures++; $display("FAIL edge_low_ch%0d: got %0d want 123", k, lo); end
         checks++; if (gap !== 10) begin failures++; $display("FAIL edge_gap_ch%0d: got %0d want 10", k, gap); end
         checks++; if (hf !== 129) begin failures++; $display("FAIL edge_hfall_ch%0d: got %0d want 129", k, hf); end
      end
      checks++; if (period_start !== 1'b1) begin failures++; $display("FAIL edge_ps_align: got %b want 1", period_start); end
   endtask

   task automatic test_center();
      int n, hi, lo, gap, hf;
      center_mode = 1'b1; dt_value = 8'd20;
      for (int k = 0; k < CHANNELS; k++) set_duty(k, 192);
      load = 1'b1;
      wait_ps(1200, n);
      wait_ps(1200, n);
      checks++; if (n !== 510) begin failures++; $display("FAIL center_period: got %0d want 510", n); end
      measure(0, 510, hi, lo, gap, hf);
      checks++; if (hi !== 363) begin failures++; $display("FAIL center_high: got %0d want 363", hi); end
      checks++; if (lo !== 107) begin failures++; $display("FAIL center_low: got %0d want 107", lo); end
      checks++; if (gap !== 40) begin failures++; $display("FAIL center_gap: got %0d want 40", gap); end
      checks++; if (hf !== 193) begin failures++; $display("FAIL center_hfall: got %0d want 193", hf); end
      checks++; if (period_start !== 1'b1) begin failures++; $display("FAIL center_ps_align: got %b want 1", period_start); end
   endtask

   task automatic test_shadow();
      int n, hi, lo, gap, hf, h1, h2;
      center_mode = 1'b0; dt_value = 8'd5;
      for (int k = 0; k < CHANNELS; k++) set_duty(k, 64);
      load = 1'b1;
      wait_ps(1200, n);
      wait_ps(1200, n);
      checks++; if (n !== 256) begin failures++; $display("FAIL shadow_period: got %0d want 256", n); end
      measure(0, 100, hi, lo, gap, hf);
      for (int k = 0; k < CHANNELS; k++) set_duty(k, 200);
      measure(0, 156, hi, lo, gap, hf);
      measure(0, 256, hi, lo, gap, hf);
      checks++; if (hi !== 59) begin failures++; $display("FAIL noload_high: got %0d want 59", hi); end
      checks++; if (lo !== 187) begin failures++; $display("FAIL noload_low: got %0d want 187", lo); end
      measure(0, 100, h1, lo, gap, hf);
      load = 1'b1;
      measure(0, 156, h2, lo, gap, hf);
      checks++; if (h1 + h2 !== 59) begin failures++; $display("FAIL midload_high: got %0d want 59", h1 + h2); end
      checks++; if (period_start !== 1'b1) begin failures++; $display("FAIL midload_ps: got %b want 1", period_start); end
      measure(0, 256, hi, lo, gap, hf);
      checks++; if (hi !== 195) begin failures++; $display("FAIL newduty_high: got %0d want 195", hi); end
      checks++; if (lo !== 51) begin failures++; $display("FAIL newduty_low: got %0d want 51", lo); end
   endtask

   task automatic test_extremes();
      int n, hi, lo, gap, hf;
      set_duty(0, 0); set_duty(1, 256); set_duty(2, 128);
      dt_value = 8'd0;
      load = 1'b1;
      wait_ps(600, n);
      wait_ps(600, n);
      measure(0, 256, hi, lo, gap, hf);
      checks++; if (hi !== 0 || lo !== 256) begin failures++; $display("FAIL duty0: got hi=%0d lo=%0d want 0/256", hi, lo); end
      measure(1, 256, hi, lo, gap, hf);
      checks++; if (hi !== 256 || lo !== 0) begin failures++; $display("FAIL duty256: got hi=%0d lo=%0d want 256/0", hi, lo); end
      measure(2, 256, hi, lo, gap, hf);
      checks++; if (hi !== 128 || lo !== 128) begin failures++; $display("FAIL dt0_split: got hi=%0d lo=%0d want 128/128", hi, lo); end
      checks++; if (gap !== 0) begin failures++; $display("FAIL dt0_gap: got %0d want 0", gap); end
   endtask

   task automatic test_prescale();
      int n, hi, lo, gap, hf;
      final_value = 8'd3; dt_value = 8'd5;
      for (int k = 0; k < CHANNELS; k++) set_duty(k, 128);
      load = 1'b1;
      wait_ps(3000, n);
      wait_ps(3000, n);
      checks++; if (n !== 1024) begin failures++; $display("FAIL presc_period: got %0d want 1024", n); end
      measure(0, 300, hi, lo, gap, hf);
      checks++; if (pwm_high[0] !== 1'b1) begin failures++; $display("FAIL presc_mid_high: got %b want 1", pwm_high[0]); end
      enable = 1'b0;
      @(negedge clk);
      checks++; if (pwm_high !== 3'b000) begin failures++; $display("FAIL disable_high: got %b want 000", pwm_high); end
      checks++; if (pwm_low !== 3'b000) begin failures++; $display("FAIL disable_low: got %b want 000", pwm_low); end
      checks++; if (period_start !== 1'b0) begin failures++; $display("FAIL disable_ps: got %b want 0", period_start); end
      enable = 1'b1;
      #1;
      checks++; if (period_start !== 1'b0) begin failures++; $display("FAIL reenable_ps_early: got %b want 0", period_start); end
      wait_ps(20, n);
      checks++; if (n !== 3) begin failures++; $display("FAIL reenable_first_tick: got %0d want 3", n); end
      measure(0, 200, hi, lo, gap, hf);
      reset = 1'b1;
      @(negedge clk);
      checks++; if ((pwm_high | pwm_low) !== 3'b000) begin failures++; $display("FAIL midreset_out: got %b/%b want 000/000", pwm_high, pwm_low); end
      reset = 1'b0;
   endtask

   task automatic test_fault();
`ifdef PWM_FAULT_EN
      int n, hi, lo, gap, hf;
      final_value = '0; dt_value = 8'd5; center_mode = 1'b0;
      for (int k = 0; k < CHANNELS; k++) set_duty(k, 128);
      load = 1'b1;
      wait_ps(600, n);
      wait_ps(600, n);
      measure(0, 50, hi, lo, gap, hf);
      checks++; if (pwm_high[0] !== 1'b1 || fault_latched !== 1'b0) begin failures++; $display("FAIL fault_pre: got high=%b latched=%b want 1/0", pwm_high[0], fault_latched); end
      fault_in = 1'b1;
      @(negedge clk);
      fault_in = 1'b0;
      checks++; if ((pwm_high | pwm_low) !== 3'b000) begin failures++; $display("FAIL fault_off: got %b/%b want 000/000", pwm_high, pwm_low); end
      checks++; if (fault_latched !== 1'b1) begin failures++; $display("FAIL fault_latch: got %b want 1", fault_latched); end
      repeat (20) @(negedge clk);
      checks++; if ((pwm_high | pwm_low) !== 3'b000 || fault_latched !== 1'b1) begin failures++; $display("FAIL fault_hold: got %b/%b latched=%b want 000/000/1", pwm_high, pwm_low, fault_latched); end
      fault_clear = 1'b1;
      @(negedge clk);
      fault_clear = 1'b0;
      checks++; if (fault_latched !== 1'b0) begin failures++; $display("FAIL fault_clear: got %b want 0", fault_latched); end
      wait_ps(600, n);
      wait_ps(600, n);
      measure(0, 256, hi, lo, gap, hf);
      checks++; if (hi !== 123 || lo !== 123) begin failures++; $display("FAIL fault_resume: got hi=%0d lo=%0d want 123/123", hi, lo); end
`endif
   endtask

   initial begin
`ifdef PWM_FAULT_EN
      fault_in = 1'b0;
      fault_clear = 1'b0;
`endif
      test_reset();
      test_edge();
      test_center();
      test_shadow();
      test_extremes();
      test_prescale();
      test_fault();
      checks++;
      if (overlaps !== 0) begin
         failures++;
         $display("FAIL overlap: got %0d cycles with high&low, want 0", overlaps);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
